// File: rtl/bit_manip_seq.sv
// Sequential bit-manipulation unit: SET/CLR/TGL plus iterative shift/rotate, owns Z/C/V/N flags.
// Latency: bit/illegal/zero-count ops -> done 1 cycle after accept; n-bit shifts -> done n+1 cycles after accept.
// Backpressure: single start/ready handshake; start is ignored while busy (ready low outside IDLE).
module bit_manip_seq #(
  parameter int WORD_SIZE = 8,
  parameter int AMT_W     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           op,
  input  logic [WORD_SIZE-1:0] operand,
  input  logic [AMT_W-1:0]     amt,
  input  logic                 flag_clr,
  output logic                 ready,
  output logic                 done,
  output logic [WORD_SIZE-1:0] result,
  output logic                 illegal,
  output logic                 zero_flag,
  output logic                 carry_flag,
  output logic                 overflow_flag,
  output logic                 negative_flag
);

  // FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Operation codes
  localparam logic [3:0] OP_SET = 4'd0;
  localparam logic [3:0] OP_CLR = 4'd1;
  localparam logic [3:0] OP_TGL = 4'd2;
  localparam logic [3:0] OP_SHL = 4'd3;
  localparam logic [3:0] OP_SHR = 4'd4;
  localparam logic [3:0] OP_SAR = 4'd5;
  localparam logic [3:0] OP_ROL = 4'd6;
  localparam logic [3:0] OP_ROR = 4'd7;
  localparam logic [3:0] OP_RCL = 4'd8;
  localparam logic [3:0] OP_RCR = 4'd9;

  localparam int MSB = WORD_SIZE - 1;
  localparam logic [WORD_SIZE-1:0] ONE_W = {{(WORD_SIZE-1){1'b0}}, 1'b1};

  // State and latched request
  logic [1:0]           state_q, state_d;
  logic [3:0]           op_q, op_d;
  logic [WORD_SIZE-1:0] work_q, work_d;
  logic [AMT_W-1:0]     cnt_q, cnt_d;
  logic                 cwork_q, cwork_d;
  logic                 vwork_q, vwork_d;

  // Architectural outputs
  logic [WORD_SIZE-1:0] result_q, result_d;
  logic                 z_q, z_d;
  logic                 c_q, c_d;
  logic                 v_q, v_d;
  logic                 n_q, n_d;

  // Decode of the incoming request
  logic                 in_is_shift;
  logic                 in_is_illegal;
  logic [WORD_SIZE-1:0] bit_mask;
  logic [WORD_SIZE-1:0] bit_res;

  // One 1-bit step of the latched shift/rotate
  logic [WORD_SIZE-1:0] step_w;
  logic                 step_c;
  logic                 step_v;

  // DONE-entry update controls
  logic                 load_res;
  logic [WORD_SIZE-1:0] res_val;
  logic                 upd_zn;
  logic                 upd_cv;
  logic                 new_c;
  logic                 new_v;

  assign in_is_shift   = (op >= OP_SHL) && (op <= OP_RCR);
  assign in_is_illegal = (op > OP_RCR);

  // A position beyond the word shifts the mask out entirely, leaving the operand unchanged
  assign bit_mask = ONE_W << amt;

  // Immediate bit-op result
  always_comb begin
    bit_res = operand;
    case (op)
      OP_SET:  bit_res = operand | bit_mask;
      OP_CLR:  bit_res = operand & ~bit_mask;
      OP_TGL:  bit_res = operand ^ bit_mask;
      default: bit_res = operand;
    endcase
  end

  // Single-position shift/rotate step on the working word; RCL/RCR rotate through the working carry
  always_comb begin
    step_w = work_q;
    step_c = cwork_q;
    case (op_q)
      OP_SHL: begin
        step_w = {work_q[MSB-1:0], 1'b0};
        step_c = work_q[MSB];
      end
      OP_SHR: begin
        step_w = {1'b0, work_q[MSB:1]};
        step_c = work_q[0];
      end
      OP_SAR: begin
        step_w = {work_q[MSB], work_q[MSB:1]};
        step_c = work_q[0];
      end
      OP_ROL: begin
        step_w = {work_q[MSB-1:0], work_q[MSB]};
        step_c = work_q[MSB];
      end
      OP_ROR: begin
        step_w = {work_q[0], work_q[MSB:1]};
        step_c = work_q[0];
      end
      OP_RCL: begin
        step_w = {work_q[MSB-1:0], cwork_q};
        step_c = work_q[MSB];
      end
      OP_RCR: begin
        step_w = {cwork_q, work_q[MSB:1]};
        step_c = work_q[0];
      end
      default: begin
        step_w = work_q;
        step_c = cwork_q;
      end
    endcase
    // Sign change on this step; only meaningful for SHL
    step_v = step_w[MSB] ^ work_q[MSB];
  end

  // FSM next state, request latching and shift iteration
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    cwork_d  = cwork_q;
    vwork_d  = vwork_q;
    load_res = 1'b0;
    res_val  = result_q;
    upd_zn   = 1'b0;
    upd_cv   = 1'b0;
    new_c    = c_q;
    new_v    = v_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          work_d  = operand;
          cnt_d   = amt;
          cwork_d = c_q;
          vwork_d = 1'b0;
          if (in_is_shift && (amt != '0)) begin
            state_d = ST_SHIFT;
          end else begin
            // Bit ops, zero-count shifts and illegal codes complete without iterating
            state_d  = ST_DONE;
            load_res = 1'b1;
            res_val  = (in_is_shift || in_is_illegal) ? operand : bit_res;
            upd_zn   = !in_is_illegal;
          end
        end
      end

      ST_SHIFT: begin
        work_d  = step_w;
        cwork_d = step_c;
        vwork_d = vwork_q | ((op_q == OP_SHL) & step_v);
        cnt_d   = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d  = ST_DONE;
          load_res = 1'b1;
          res_val  = step_w;
          upd_zn   = 1'b1;
          upd_cv   = 1'b1;
          new_c    = step_c;
          new_v    = (op_q == OP_SHL) ? (vwork_q | step_v) : 1'b0;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Result and flag next values; a coincident flag_clr overrides the DONE-entry flag update
  always_comb begin
    result_d = load_res ? res_val : result_q;
    z_d      = z_q;
    c_d      = c_q;
    v_d      = v_q;
    n_d      = n_q;
    if (upd_zn) begin
      z_d = (res_val == '0);
      n_d = res_val[MSB];
    end
    if (upd_cv) begin
      c_d = new_c;
      v_d = new_v;
    end
    if (flag_clr) begin
      z_d = 1'b0;
      c_d = 1'b0;
      v_d = 1'b0;
      n_d = 1'b0;
    end
  end

  // Control state registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      cwork_q <= 1'b0;
      vwork_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      cwork_q <= cwork_d;
      vwork_q <= vwork_d;
    end
  end

  // Architectural result and flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      result_q <= result_d;
      z_q      <= z_d;
      c_q      <= c_d;
      v_q      <= v_d;
      n_q      <= n_d;
    end
  end

  assign ready         = (state_q == ST_IDLE);
  assign done          = (state_q == ST_DONE);
  assign illegal       = done && (op_q > OP_RCR);
  assign result        = result_q;
  assign zero_flag     = z_q;
  assign carry_flag    = c_q;
  assign overflow_flag = v_q;
  assign negative_flag = n_q;

endmodule

// File: tb/tb_bit_manip_seq.sv
// Directed self-checking bench for bit_manip_seq.
// Inputs driven 1 time unit after rising edges; outputs sampled at the same offset.
// Every wait on done is bounded; a timeout shows up as a failed comparison.
module tb_bit_manip_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] op;
  logic [7:0] operand;
  logic [2:0] amt;
  logic       flag_clr;
  logic       ready;
  logic       done;
  logic [7:0] result;
  logic       illegal;
  logic       zero_flag;
  logic       carry_flag;
  logic       overflow_flag;
  logic       negative_flag;

  int n_cmp;
  int n_fail;

  bit_manip_seq #(.WORD_SIZE(8), .AMT_W(3)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .op            (op),
    .operand       (operand),
    .amt           (amt),
    .flag_clr      (flag_clr),
    .ready         (ready),
    .done          (done),
    .result        (result),
    .illegal       (illegal),
    .zero_flag     (zero_flag),
    .carry_flag    (carry_flag),
    .overflow_flag (overflow_flag),
    .negative_flag (negative_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // flags packed as {Z,C,V,N}
  function automatic logic [3:0] flags();
    return {zero_flag, carry_flag, overflow_flag, negative_flag};
  endfunction

  // Present a request for exactly one edge (the acceptance edge k)
  task automatic issue(input logic [3:0] o, input logic [7:0] d, input logic [2:0] a);
    start   = 1'b1;
    op      = o;
    operand = d;
    amt     = a;
    @(posedge clk);
    #1;
    start   = 1'b0;
  endtask

  // Count extra edges after acceptance until done is seen (bounded)
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // Check a completed operation, then the return to IDLE
  task automatic finish_op(input string tag, input int exp_lat, input logic [7:0] exp_res,
                           input logic [3:0] exp_flags, input logic exp_ill);
    int lat;
    wait_done(lat);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_result"}, {24'd0, result}, {24'd0, exp_res});
    chk({tag, "_flags_zcvn"}, {28'd0, flags()}, {28'd0, exp_flags});
    chk({tag, "_illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
    @(posedge clk);
    #1;
    chk({tag, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    int seen;
    n_cmp    = 0;
    n_fail   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    op       = 4'd0;
    operand  = 8'd0;
    amt      = 3'd0;
    flag_clr = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_flags", {28'd0, flags()}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: SET bit 3, then CLR bit 7
    issue(4'd0, 8'b1010_0010, 3'd3);
    finish_op("set", 0, 8'b1010_1010, 4'b0001, 1'b0);
    issue(4'd1, 8'b1111_1111, 3'd7);
    finish_op("clr", 0, 8'b0111_1111, 4'b0000, 1'b0);

    // 2: SHL by 2 with a start pulse during SHIFT that must be ignored
    issue(4'd3, 8'b1100_1100, 3'd2);
    chk("shl_ready_shift1", {31'd0, ready}, 32'd0);
    start = 1'b1; op = 4'd0; operand = 8'h00; amt = 3'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("shl_ready_shift2", {31'd0, ready}, 32'd0);
    chk("shl_no_early_done", {31'd0, done}, 32'd0);
    finish_op("shl", 1, 8'b0011_0000, 4'b0110, 1'b0);

    // 3: ROR by 3, then RCR by 1 with carry in = 1
    issue(4'd7, 8'b1100_1100, 3'd3);
    finish_op("ror", 3, 8'b1001_1001, 4'b0101, 1'b0);
    issue(4'd9, 8'b0000_0001, 3'd1);
    finish_op("rcr", 1, 8'b1000_0000, 4'b0101, 1'b0);

    // 4: SAR by 7, then SHR by 1 to zero
    issue(4'd5, 8'b1000_0000, 3'd7);
    finish_op("sar", 7, 8'b1111_1111, 4'b0001, 1'b0);
    issue(4'd4, 8'b0000_0001, 3'd1);
    finish_op("shr", 1, 8'b0000_0000, 4'b1100, 1'b0);

    // TGL leaves C and V alone; gives a nonzero result before the reset test
    issue(4'd2, 8'h00, 3'd0);
    finish_op("tgl", 0, 8'h01, 4'b0100, 1'b0);

    // 5: reset in the middle of a 5-step SHL
    issue(4'd3, 8'h81, 3'd5);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_ready", {31'd0, ready}, 32'd1);
    chk("abort_result", {24'd0, result}, 32'd0);
    chk("abort_flags", {28'd0, flags()}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen = 1;
    end
    chk("abort_no_done", seen, 0);
    chk("abort_ready_after", {31'd0, ready}, 32'd1);

    // 6: set C via ROL, illegal op keeps flags, zero-count SHL keeps C/V
    issue(4'd6, 8'h81, 3'd1);
    finish_op("rol", 1, 8'h03, 4'b0100, 1'b0);
    issue(4'hF, 8'h5A, 3'd2);
    finish_op("illegal_op", 0, 8'h5A, 4'b0100, 1'b1);
    issue(4'd3, 8'h80, 3'd0);
    finish_op("shl_amt0", 0, 8'h80, 4'b0101, 1'b0);

    // flag_clr coincident with the SHL DONE-entry edge
    issue(4'd3, 8'h80, 3'd1);
    flag_clr = 1'b1;
    @(posedge clk);
    #1;
    flag_clr = 1'b0;
    chk("fclr_done", {31'd0, done}, 32'd1);
    chk("fclr_result", {24'd0, result}, 32'd0);
    chk("fclr_flags", {28'd0, flags()}, 32'd0);
    @(posedge clk);
    #1;
    chk("fclr_ready_back", {31'd0, ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
